// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, decoder state encoding and the set-2 scan code to ASCII map.
`timescale 1ns/1ps
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

    // Unmapped codes return 0, which the decoder treats as "do not push".
    function automatic logic [7:0] scan2ascii(input logic [7:0] code);
        logic [7:0] a;
        a = 8'h00;
        case (code)
            8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
            8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
            8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
            8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
            8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
            8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            8'h29: a = 8'h20;
            8'h5A: a = 8'h0D;
            8'h66: a = 8'h08;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/ps2_key_receiver_if.sv
// PS/2 line inputs and ASCII queue read side of the key receiver.
`timescale 1ns/1ps
interface ps2_key_receiver_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rd_en;
    logic       ready;
    logic [7:0] ascii;
    logic [7:0] scan_code;
    logic       overflow;
    logic       frame_err;

    modport master (output ps2_clk, ps2_data, rd_en,
                    input  ready, ascii, scan_code, overflow, frame_err);
    modport slave  (input  ps2_clk, ps2_data, rd_en,
                    output ready, ascii, scan_code, overflow, frame_err);
endinterface

// File: rtl/ps2_ascii_fifo.sv
// Synchronous 8-bit FIFO; head is shown combinationally from the registered read pointer.
`timescale 1ns/1ps
module ps2_ascii_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic       ready,
    output logic [7:0] dout,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0] count;
    logic        overflow_reg;
    logic        empty, full, do_pop, do_push;

    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push on full still lands.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && full && !do_pop) overflow_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
    end

    assign ready    = ~empty;
    assign dout     = empty ? 8'h00 : mem[rd_ptr_reg[AW-1:0]];
    assign overflow = overflow_reg;
endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 frame receiver plus set-2 make-code decoder feeding an ASCII FIFO.
// Optional SHIFT_CASE_EN: track left/right shift and push uppercase letters while held.
`timescale 1ns/1ps
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic               clk,
    input  logic               clrn,
    ps2_key_receiver_if.slave  bus
);
    logic [2:0]  clk_sync_reg, dat_sync_reg;
    logic        ps2_fall, ps2_bit;
    logic [3:0]  bit_cnt_reg;
    logic [9:0]  shift_reg;
    logic [15:0] to_cnt_reg;
    logic        byte_vld_reg, frame_err_reg, frame_ok;
    logic [7:0]  scan_code_reg;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_reg <= '0;
            dat_sync_reg <= '0;
        end else begin
            clk_sync_reg <= {clk_sync_reg[1:0], bus.ps2_clk};
            dat_sync_reg <= {dat_sync_reg[1:0], bus.ps2_data};
        end
    end

    assign ps2_fall = (clk_sync_reg[2:1] == 2'b10);
    assign ps2_bit  = dat_sync_reg[2];
    // shift_reg holds bits 0..9 (start at [0], parity at [9]); ps2_bit is the stop bit.
    assign frame_ok = !shift_reg[0] && ps2_bit && (^shift_reg[9:1]);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            to_cnt_reg    <= '0;
            byte_vld_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            scan_code_reg <= '0;
        end else begin
            byte_vld_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            if (ps2_fall) begin
                to_cnt_reg <= '0;
                if (bit_cnt_reg == 4'd10) begin
                    bit_cnt_reg <= '0;
                    if (frame_ok) begin
                        scan_code_reg <= shift_reg[8:1];
                        byte_vld_reg  <= 1'b1;
                    end else begin
                        frame_err_reg <= 1'b1;
                    end
                end else begin
                    shift_reg   <= {ps2_bit, shift_reg[9:1]};
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                end
            end else if (bit_cnt_reg != 4'd0) begin
                if (to_cnt_reg == 16'(TIMEOUT_CYC - 1)) begin
                    bit_cnt_reg <= '0;
                    to_cnt_reg  <= '0;
                end else begin
                    to_cnt_reg <= to_cnt_reg + 16'd1;
                end
            end
        end
    end

    dec_state_t state_reg, state_next;
    logic       push_reg, push_next;
    logic [7:0] push_data_reg, push_data_next;
    logic [7:0] code_ascii, push_char;

    assign code_ascii = scan2ascii(scan_code_reg);

`ifdef SHIFT_CASE_EN
    logic shift_l_reg, shift_l_next, shift_r_reg, shift_r_next;
    assign push_char = ((shift_l_reg | shift_r_reg) && code_ascii >= 8'h61 && code_ascii <= 8'h7A)
                       ? code_ascii - 8'h20 : code_ascii;
`else
    assign push_char = code_ascii;
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg     <= ST_IDLE;
            push_reg      <= 1'b0;
            push_data_reg <= '0;
`ifdef SHIFT_CASE_EN
            shift_l_reg   <= 1'b0;
            shift_r_reg   <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            push_reg      <= push_next;
            push_data_reg <= push_data_next;
`ifdef SHIFT_CASE_EN
            shift_l_reg   <= shift_l_next;
            shift_r_reg   <= shift_r_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        push_next      = 1'b0;
        push_data_next = 8'h00;
`ifdef SHIFT_CASE_EN
        shift_l_next   = shift_l_reg;
        shift_r_next   = shift_r_reg;
`endif
        if (byte_vld_reg) begin
            case (state_reg)
                ST_IDLE: begin
                    if (scan_code_reg == PS2_BREAK)      state_next = ST_BRK;
                    else if (scan_code_reg == PS2_EXT)   state_next = ST_EXT;
`ifdef SHIFT_CASE_EN
                    else if (scan_code_reg == PS2_LSHIFT) shift_l_next = 1'b1;
                    else if (scan_code_reg == PS2_RSHIFT) shift_r_next = 1'b1;
`endif
                    else if (code_ascii != 8'h00) begin
                        push_next      = 1'b1;
                        push_data_next = push_char;
                    end
                end
                ST_BRK: begin
                    state_next = ST_IDLE;
`ifdef SHIFT_CASE_EN
                    if (scan_code_reg == PS2_LSHIFT) shift_l_next = 1'b0;
                    if (scan_code_reg == PS2_RSHIFT) shift_r_next = 1'b0;
`endif
                end
                ST_EXT:     state_next = (scan_code_reg == PS2_BREAK) ? ST_EXT_BRK : ST_IDLE;
                ST_EXT_BRK: state_next = ST_IDLE;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    ps2_ascii_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .clrn     (clrn),
        .push     (push_reg),
        .din      (push_data_reg),
        .pop      (bus.rd_en),
        .ready    (bus.ready),
        .dout     (bus.ascii),
        .overflow (bus.overflow)
    );

    assign bus.scan_code = scan_code_reg;
    assign bus.frame_err = frame_err_reg;
endmodule
